fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arb_pkg.sv | 14 +
 rtl/fb_fill_seq.sv | 59 +++++
 rtl/fb_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the framebuffer arbiter: FSM state encoding,
// stall counter width and line counter width.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DRAW = 2'd2
  } arb_state_t;

  localparam int STALL_W    = 16;
  localparam int LINE_CNT_W = 6;

endpackage

// File: rtl/fb_fill_seq.sv
// Fill sequencer: tracks which display line maps onto a new framebuffer line
// and the framebuffer address the next linebuffer fill reads from.
module fb_fill_seq
  import fb_arb_pkg::*;
#(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int FB_SCALE  = 4,
  parameter int ADDRW     = 15
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic             frame_sys,
  input  logic             line_sys,
  input  logic             lb_line,
  input  logic             lb_first,
  input  logic             fill_step,
  output logic [ADDRW-1:0] fill_addr,
  output logic             fill_line
);

  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(FB_SCALE - 1);
  localparam logic [ADDRW-1:0]      LAST_ADDR = ADDRW'(FB_WIDTH * FB_HEIGHT - 1);

  logic [LINE_CNT_W-1:0] cnt_line;
  logic [LINE_CNT_W-1:0] cnt_next;
  logic                  line_evt;

  // A frame pulse in the same cycle swallows the line pulse entirely.
  assign line_evt = line_sys & ~frame_sys;

  always_comb begin
    cnt_next = cnt_line;
    if (lb_first) begin
      cnt_next = '0;
    end else if (lb_line) begin
      cnt_next = (cnt_line == LAST_LINE) ? '0 : cnt_line + LINE_CNT_W'(1);
    end
  end

  assign fill_line = line_evt & lb_line & (cnt_next == '0);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      cnt_line  <= '0;
      fill_addr <= '0;
    end else begin
      if (line_evt) begin
        cnt_line <= cnt_next;
      end
      if (frame_sys) begin
        fill_addr <= '0;
      end else if (fill_step) begin
        fill_addr <= (fill_addr == LAST_ADDR) ? '0 : fill_addr + ADDRW'(1);
      end
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer BRAM arbiter: linebuffer fills take priority over
// draw-port accesses. Define FBARB_STATS_EN to build the draw stall counter.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter  int FB_WIDTH  = 160,
  parameter  int FB_HEIGHT = 120,
  parameter  int FB_SCALE  = 4,
  parameter  int DATAW     = 4,
  localparam int ADDRW     = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic               clk_sys,
  input  logic               rst_sys_n,
  input  logic               frame_sys,
  input  logic               line_sys,
  input  logic               lb_line,
  input  logic               lb_first,
  input  logic               drw_req,
  input  logic               drw_we,
  input  logic [ADDRW-1:0]   drw_addr,
  input  logic [DATAW-1:0]   drw_data,
  output logic               drw_ack,
  output logic [DATAW-1:0]   drw_rdata,
  output logic               drw_rvalid,
  output logic [ADDRW-1:0]   fb_addr,
  output logic               fb_we,
  output logic [DATAW-1:0]   fb_din,
  input  logic [DATAW-1:0]   fb_dout,
  output logic               lb_en_in,
  output logic [DATAW-1:0]   lb_data,
  output logic               overrun,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int              CNTW     = $clog2(FB_WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_COL = CNTW'(FB_WIDTH - 1);

  arb_state_t       state;
  logic [CNTW-1:0]  fill_cnt;
  logic [ADDRW-1:0] fill_addr;
  logic             fill_line;
  logic             start_fill;
  logic             fill_read;
  logic             grant;
  logic             fill_out;

  fb_fill_seq #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .FB_SCALE  (FB_SCALE),
    .ADDRW     (ADDRW)
  ) u_fill_seq (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .frame_sys (frame_sys),
    .line_sys  (line_sys),
    .lb_line   (lb_line),
    .lb_first  (lb_first),
    .fill_step (fill_read),
    .fill_addr (fill_addr),
    .fill_line (fill_line)
  );

  // The first read of a fill goes out in the same cycle as the line pulse.
  assign start_fill = fill_line & (state != ST_FILL);
  assign fill_read  = start_fill | ((state == ST_FILL) & ~frame_sys);
  assign grant      = drw_req & (state != ST_FILL) & ~start_fill;

  // Outputs driven straight from inputs are forced quiet while in reset.
  assign fill_out = fill_read & rst_sys_n;
  assign drw_ack  = grant & rst_sys_n;
  assign fb_we    = drw_ack & drw_we;
  assign fb_din   = drw_ack ? drw_data : '0;
  assign fb_addr  = fill_out ? fill_addr : (drw_ack ? drw_addr : '0);

  assign lb_data   = lb_en_in ? fb_dout : '0;
  assign drw_rdata = drw_rvalid ? fb_dout : '0;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state      <= ST_IDLE;
      fill_cnt   <= '0;
      lb_en_in   <= 1'b0;
      drw_rvalid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      lb_en_in   <= fill_read;
      drw_rvalid <= grant & ~drw_we;

      if (frame_sys) begin
        overrun <= 1'b0;
      end else if (line_sys && state == ST_FILL) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_FILL: begin
          if (frame_sys || fill_cnt == LAST_COL) begin
            state    <= ST_IDLE;
            fill_cnt <= '0;
          end else begin
            fill_cnt <= fill_cnt + CNTW'(1);
          end
        end
        default: begin
          if (start_fill) begin
            state    <= (FB_WIDTH > 1) ? ST_FILL : ST_IDLE;
            fill_cnt <= CNTW'(1);
          end else begin
            state    <= drw_req ? ST_DRAW : ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef FBARB_STATS_EN
  logic [STALL_W-1:0] stall_q;

  // Counts cycles the draw port was held off; saturates rather than wrapping.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      stall_q <= '0;
    end else if (frame_sys) begin
      stall_q <= '0;
    end else if (drw_req && !grant && stall_q != '1) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
